segment_action_reader: RTL

SEGMENT_ACTION_READER -- requirements
Module: segment_action_reader

---
 rtl/segment_action_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/segment_action_reader.sv
// Recovers action codes from synchronized seven-segment lines.
// Optional ambig output enabled by macro SEG_READER_AMBIG_EN.
module segment_action_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       ready,
    input  logic       clr,
    output logic [2:0] code,
    output logic       valid,
    output logic       err,
`ifdef SEG_READER_AMBIG_EN
    output logic       ambig,
`endif
    output logic       ovf
);

    typedef enum logic {S_IDLE, S_PEND} state_t;

    localparam logic [3:0] CMAX = 4'(STABLE_CYCLES);
    localparam logic [6:0] PAT_AMB = 7'b1111010;

    logic [6:0] r_s1;
    logic [6:0] r_s2;
    logic [3:0] r_cnt;
    logic       r_hit;
    logic [6:0] r_last;
    logic       r_last_vld;
    logic [2:0] r_code;
    logic       r_err;
    logic       r_ovf;
    state_t     r_state;
    state_t     w_state_nxt;

    logic [6:0] w_pat;
    logic       w_qual;
    logic       w_known;
    logic [2:0] w_dec;
    logic       w_blank;
    logic       w_dup;
    logic       w_load;
    logic       w_err_set;
    logic       w_ovf_set;

    assign w_pat = {a, b, c, d, e, f, g};

    // The counter restarts on the edge where the new pattern reaches stage 2,
    // so it counts samples of the stage-2 pattern that matched its successor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_cnt <= '0;
            r_hit <= 1'b0;
        end else begin
            r_s1  <= w_pat;
            r_s2  <= r_s1;
            r_hit <= (r_cnt == CMAX);
            if (r_s1 != r_s2)
                r_cnt <= '0;
            else if (r_cnt != CMAX)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    assign w_qual = (r_cnt == CMAX) && !r_hit;

    always_comb begin
        w_known = 1'b1;
        w_dec   = 3'd0;
        unique case (r_s2)
            7'b1111010: w_dec = 3'd0;
            7'b0001000: w_dec = 3'd1;
            7'b0110001: w_dec = 3'd2;
            7'b1110001: w_dec = 3'd3;
            7'b0100100: w_dec = 3'd4;
            7'b1100000: w_dec = 3'd5;
            default:    w_known = 1'b0;
        endcase
    end

    assign w_blank   = (r_s2 == 7'd0);
    assign w_dup     = r_last_vld && (r_last == r_s2);
    assign w_load    = w_qual && w_known && !w_dup;
    assign w_err_set = w_qual && !w_known && !w_blank;
    assign w_ovf_set = w_load && (r_state == S_PEND) && !ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_load) w_state_nxt = S_PEND;
            S_PEND: if (!w_load && ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_code     <= '0;
            r_last     <= '0;
            r_last_vld <= 1'b0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_code     <= w_dec;
                r_last     <= r_s2;
                r_last_vld <= 1'b1;
            end else if (w_qual && w_blank) begin
                r_last_vld <= 1'b0;
            end
            // A set in the same cycle as clr wins.
            if (w_err_set)
                r_err <= 1'b1;
            else if (clr)
                r_err <= 1'b0;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (clr)
                r_ovf <= 1'b0;
        end
    end

`ifdef SEG_READER_AMBIG_EN
    logic r_ambig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ambig <= 1'b0;
        else if (w_load)
            r_ambig <= (r_s2 == PAT_AMB);
    end

    assign ambig = r_ambig;
`else
    logic w_unused;
    assign w_unused = ^PAT_AMB;
`endif

    assign code  = r_code;
    assign valid = (r_state == S_PEND);
    assign err   = r_err;
    assign ovf   = r_ovf;

endmodule
